// File: rtl/seq_slice_adder_16.sv
// seq_slice_adder_16 -- time-multiplexed sliced adder.
// Computes {cout,sum} = a + b + cin one SLICE_W-bit slice per clock through a
// small ripple-carry slice, carrying between slices in a register.
// Handshake: start accepted in IDLE or DONE, busy high during RUN, done is a
// one-cycle pulse when the registered result becomes valid.
// Optional feature: define OVERFLOW_FLAG_EN to add the signed-overflow output ovf_o.
module seq_slice_adder_16 #(
  parameter int WIDTH   = 16,
  parameter int SLICE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int N     = WIDTH / SLICE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               ovf_q;

  logic               load;
  logic               commit;
  logic               last_slice;
  int                 base;
  logic [SLICE_W-1:0] a_sl, b_sl, s_sl;
  logic               c_rip;

  // Ripple-carry slice: adds the indexed operand slices plus the carry register.
  always_comb begin
    base  = int'(idx_q) * SLICE_W;
    a_sl  = a_q[base +: SLICE_W];
    b_sl  = b_q[base +: SLICE_W];
    s_sl  = '0;
    // NOTE: c_rip is a combinational temporary re-assigned each bit, so blocking
    // assignments are required here; sequential state below uses non-blocking only.
    c_rip = carry_q;
    for (int i = 0; i < SLICE_W; i++) begin
      s_sl[i] = a_sl[i] ^ b_sl[i] ^ c_rip;
      c_rip   = (a_sl[i] & b_sl[i]) | (c_rip & (a_sl[i] ^ b_sl[i]));
    end
    res_d             = res_q;
    res_d[base +: SLICE_W] = s_sl;
    last_slice        = (idx_q == LAST_IDX);
  end

  // Next-state logic for the IDLE/RUN/DONE sequencer and slice bookkeeping.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    load    = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          load    = 1'b1;
          idx_d   = '0;
          carry_d = cin_i;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        carry_d = c_rip;
        if (last_slice) begin
          idx_d   = '0;
          commit  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers; synchronous reset drops any in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      if (commit) begin
        sum_q  <= res_d;
        cout_q <= c_rip;
        ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
      end
    end
  end

  // Operand capture and partial-result register.
  // NOTE: these datapath registers need no reset: they are always loaded or fully
  // overwritten before anything derived from them becomes visible.
  always_ff @(posedge clk) begin
    if (load) begin
      a_q <= a_i;
      b_q <= b_i;
    end
    if (state_q == S_RUN) begin
      res_q <= res_d;
    end
  end

  assign busy_o = (state_q == S_RUN);
  assign done_o = (state_q == S_DONE);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;
`ifdef OVERFLOW_FLAG_EN
  assign ovf_o  = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule
